// File: rtl/chain_loader.sv
// chain_loader: programs the serial configuration chain from a parallel image.
// Shifts the image out MSB first on din/scl framed by cs, captures dout into
// readback, and optionally re-shifts the same image to verify the chain.
//
// Ports:
//   clk       system clock
//   reset     asynchronous reset, active-low
//   start     single-cycle load request, accepted only in IDLE
//   verify    sampled with start; 1 = run a second compare pass
//   image     chain contents, latched on an accepted start
//   busy      high from the cycle after an accepted start until done
//   done      one-cycle pulse at the end of the operation
//   err       verify mismatch, sticky until the next accepted start
//   readback  bits shifted out of the chain during the last pass
//   scl       chain serial clock
//   cs        chain select, active-high
//   din       chain serial data
//   dout      chain serial data return
module chain_loader #(
  parameter int unsigned CHAIN_LEN = 264,
  parameter int unsigned DIV       = 4,
  parameter int unsigned CS_SETUP  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 verify,
  input  logic [CHAIN_LEN-1:0] image,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [CHAIN_LEN-1:0] readback,
  output logic                 scl,
  output logic                 cs,
  output logic                 din,
  input  logic                 dout
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned BIT_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [BIT_W-1:0] BIT_MSB    = BIT_W'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic                 phase_q, phase_d;
  logic                 pass_q, pass_d;
  logic                 verify_q, verify_d;
  logic [CHAIN_LEN-1:0] shadow_q, shadow_d;
  logic                 sample;

  logic                 scl_d, cs_d, din_d, busy_d, done_d, err_d;
  logic [CHAIN_LEN-1:0] readback_d;

  // State register and sequencing counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      phase_q  <= 1'b0;
      pass_q   <= 1'b0;
      verify_q <= 1'b0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      phase_q  <= phase_d;
      pass_q   <= pass_d;
      verify_q <= verify_d;
      shadow_q <= shadow_d;
    end
  end

  // Next-state: phase_q 0 = scl low half, 1 = scl high half of the current bit
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    bit_d    = bit_q;
    phase_d  = phase_q;
    pass_d   = pass_q;
    verify_d = verify_q;
    shadow_d = shadow_q;
    sample   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d  = SETUP;
          shadow_d = image;
          verify_d = verify;
          pass_d   = 1'b0;
          bit_d    = BIT_MSB;
          phase_d  = 1'b0;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = SHIFT;
          cnt_d   = '0;
          phase_d = 1'b0;
        end
      end
      SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!phase_q) begin
            // Rising scl edge: capture dout before the chain shifts
            phase_d = 1'b1;
            sample  = 1'b1;
          end else if (bit_q == '0) begin
            state_d = HOLD;
            phase_d = 1'b0;
          end else begin
            phase_d = 1'b0;
            bit_d   = bit_q - BIT_W'(1);
          end
        end
      end
      HOLD: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (verify_q && !pass_q) begin
            state_d = SETUP;
            pass_d  = 1'b1;
            bit_d   = BIT_MSB;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Output decode: next values of the registered pin/status outputs
  always_comb begin
    scl_d      = 1'b0;
    cs_d       = 1'b0;
    din_d      = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = err;
    readback_d = readback;
    case (state_d)
      SETUP, SHIFT: begin
        cs_d   = 1'b1;
        busy_d = 1'b1;
        din_d  = shadow_d[bit_d];
        scl_d  = (state_d == SHIFT) && phase_d;
      end
      HOLD:    busy_d = 1'b1;
      DONE:    done_d = 1'b1;
      default: ;
    endcase
    if (state_q == IDLE && start) begin
      err_d = 1'b0;
    end
    // Only a verify operation reaches DONE from HOLD with verify_q set (pass 1)
    if (state_q == HOLD && state_d == DONE && verify_q) begin
      err_d = (readback != shadow_q);
    end
    if (sample) begin
      readback_d = {readback[CHAIN_LEN-2:0], dout};
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl      <= 1'b0;
      cs       <= 1'b0;
      din      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      readback <= '0;
    end else begin
      scl      <= scl_d;
      cs       <= cs_d;
      din      <= din_d;
      busy     <= busy_d;
      done     <= done_d;
      err      <= err_d;
      readback <= readback_d;
    end
  end

endmodule

// File: tb/tb_chain_loader.sv
// Testbench for chain_loader: an 8-bit chain instance (DIV=2, CS_SETUP=2) for
// directed protocol checks and a full 264-bit instance (DIV=4) for a verify
// run. Each instance drives a behavioural chain shift-register model.
module tb_chain_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // 8-bit instance
  logic       start_a, verify_a, busy_a, done_a, err_a, scl_a, cs_a, din_a, dout_a;
  logic [7:0] image_a, readback_a;

  // 264-bit instance
  logic         start_b, verify_b, busy_b, done_b, err_b, scl_b, cs_b, din_b, dout_b;
  logic [263:0] image_b, readback_b;

  chain_loader #(.CHAIN_LEN(8), .DIV(2), .CS_SETUP(2)) dut_a (
    .clk(clk), .reset(rst_n), .start(start_a), .verify(verify_a), .image(image_a),
    .busy(busy_a), .done(done_a), .err(err_a), .readback(readback_a),
    .scl(scl_a), .cs(cs_a), .din(din_a), .dout(dout_a)
  );

  chain_loader #(.CHAIN_LEN(264), .DIV(4), .CS_SETUP(2)) dut_b (
    .clk(clk), .reset(rst_n), .start(start_b), .verify(verify_b), .image(image_b),
    .busy(busy_b), .done(done_b), .err(err_b), .readback(readback_b),
    .scl(scl_b), .cs(cs_b), .din(din_b), .dout(dout_b)
  );

  // Chain model A: shifts on each scl rise; optional cell-3 fault drops bit 3 when cs falls
  logic [7:0]  chain_a, pre_a;
  logic        load_a, stuck_a, scl_p_a, cs_p_a;
  int          edges_a, frames_a, dones_a;
  logic [15:0] dinlog_a;
  assign dout_a = chain_a[7];

  always @(posedge clk) begin
    scl_p_a <= scl_a;
    cs_p_a  <= cs_a;
    if (load_a) begin
      chain_a  <= pre_a;
      edges_a  <= 0;
      frames_a <= 0;
      dones_a  <= 0;
      dinlog_a <= '0;
    end else begin
      if (scl_a && !scl_p_a) begin
        chain_a  <= {chain_a[6:0], din_a};
        edges_a  <= edges_a + 1;
        dinlog_a <= {dinlog_a[14:0], din_a};
      end else if (!cs_a && cs_p_a && stuck_a) begin
        chain_a[3] <= 1'b0;
      end
      if (cs_a && !cs_p_a) frames_a <= frames_a + 1;
      if (done_a) dones_a <= dones_a + 1;
    end
  end

  // Chain model B
  logic [263:0] chain_b, pre_b;
  logic         load_b, scl_p_b;
  int           edges_b;
  assign dout_b = chain_b[263];

  always @(posedge clk) begin
    scl_p_b <= scl_b;
    if (load_b) begin
      chain_b <= pre_b;
      edges_b <= 0;
    end else if (scl_b && !scl_p_b) begin
      chain_b <= {chain_b[262:0], din_b};
      edges_b <= edges_b + 1;
    end
  end

  int n_cmp;
  int n_fail;

  task automatic prep_a(input logic [7:0] p, input logic st);
    @(negedge clk);
    pre_a = p; stuck_a = st; load_a = 1'b1;
    @(negedge clk);
    load_a = 1'b0;
  endtask

  // Start a load on A and run until done (cycle 1 = first cycle after acceptance)
  task automatic run_a(input logic [7:0] img, input logic ver, input int inj,
                       input bit inj_done, output int done_cyc, output int busy_cyc);
    int c;
    done_cyc = 0; busy_cyc = 0; c = 1;
    @(negedge clk);
    image_a = img; verify_a = ver; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; image_a = 8'h00; verify_a = 1'b0;
    while (done_cyc == 0 && c <= 200) begin
      if (busy_a) busy_cyc++;
      if (done_a) done_cyc = c;
      start_a = 1'b0;
      if (c == inj) begin
        start_a = 1'b1; image_a = 8'h00; verify_a = 1'b1;
      end
      if (done_a && inj_done) start_a = 1'b1;
      @(negedge clk);
      c++;
    end
    start_a = 1'b0; verify_a = 1'b0;
  endtask

  task automatic run_b(input logic [263:0] img, input logic ver,
                       output int done_cyc, output int busy_cyc);
    int c;
    done_cyc = 0; busy_cyc = 0; c = 1;
    @(negedge clk);
    image_b = img; verify_b = ver; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0; image_b = '0; verify_b = 1'b0;
    while (done_cyc == 0 && c <= 6000) begin
      if (busy_b) busy_cyc++;
      if (done_b) done_cyc = c;
      @(negedge clk);
      c++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({scl_a, cs_a, din_a, busy_a, done_a, err_a} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_pins_a: got %b expected 000000", {scl_a, cs_a, din_a, busy_a, done_a, err_a});
    end
    n_cmp++;
    if (readback_a !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_readback_a: got %h expected 00", readback_a);
    end
    n_cmp++;
    if ({scl_b, cs_b, din_b, busy_b, done_b, err_b, |readback_b} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_b: got %b expected 0000000", {scl_b, cs_b, din_b, busy_b, done_b, err_b, |readback_b});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid();
    prep_a(8'h3C, 1'b0);
    @(negedge clk);
    image_a = 8'hA5; verify_a = 1'b0; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (9) @(negedge clk);
    // cycle 10: high phase of the second bit
    n_cmp++;
    if ({scl_a, cs_a, busy_a} !== 3'b111) begin
      n_fail++;
      $display("FAIL midshift_active: got %b expected 111", {scl_a, cs_a, busy_a});
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({scl_a, cs_a, din_a, busy_a, done_a} !== 5'b0) begin
      n_fail++;
      $display("FAIL midreset_pins: got %b expected 00000", {scl_a, cs_a, din_a, busy_a, done_a});
    end
    n_cmp++;
    if (readback_a !== 8'h00) begin
      n_fail++;
      $display("FAIL midreset_readback: got %h expected 00", readback_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    prep_a(8'h3C, 1'b0);
    repeat (20) @(negedge clk);
    n_cmp++;
    if (edges_a !== 0 || busy_a !== 1'b0 || dones_a !== 0) begin
      n_fail++;
      $display("FAIL postreset_idle: edges %0d busy %b dones %0d expected 0 0 0", edges_a, busy_a, dones_a);
    end
  endtask

  task automatic test_single();
    int dc, bc;
    prep_a(8'h3C, 1'b0);
    run_a(8'hA5, 1'b0, 0, 1'b0, dc, bc);
    n_cmp++;
    if (edges_a !== 8 || frames_a !== 1) begin
      n_fail++;
      $display("FAIL single_edges: edges %0d frames %0d expected 8 1", edges_a, frames_a);
    end
    n_cmp++;
    if (dinlog_a[7:0] !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_din: got %h expected a5", dinlog_a[7:0]);
    end
    n_cmp++;
    if (readback_a !== 8'h3C) begin
      n_fail++;
      $display("FAIL single_readback: got %h expected 3c", readback_a);
    end
    n_cmp++;
    if (dc !== 37 || bc !== 36) begin
      n_fail++;
      $display("FAIL single_timing: done at %0d busy %0d expected 37 36", dc, bc);
    end
    n_cmp++;
    if (err_a !== 1'b0 || chain_a !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_state: err %b chain %h expected 0 a5", err_a, chain_a);
    end
  endtask

  task automatic test_verify_good();
    int dc, bc;
    prep_a(8'h3C, 1'b0);
    run_a(8'hA5, 1'b1, 0, 1'b0, dc, bc);
    n_cmp++;
    if (edges_a !== 16 || frames_a !== 2) begin
      n_fail++;
      $display("FAIL verify_edges: edges %0d frames %0d expected 16 2", edges_a, frames_a);
    end
    n_cmp++;
    if (dinlog_a !== 16'hA5A5) begin
      n_fail++;
      $display("FAIL verify_din: got %h expected a5a5", dinlog_a);
    end
    n_cmp++;
    if (readback_a !== 8'hA5 || err_a !== 1'b0) begin
      n_fail++;
      $display("FAIL verify_result: readback %h err %b expected a5 0", readback_a, err_a);
    end
    n_cmp++;
    if (dc !== 73 || bc !== 72) begin
      n_fail++;
      $display("FAIL verify_timing: done at %0d busy %0d expected 73 72", dc, bc);
    end
  endtask

  task automatic test_verify_fault();
    int dc, bc;
    prep_a(8'h00, 1'b1);
    run_a(8'hFF, 1'b1, 0, 1'b0, dc, bc);
    n_cmp++;
    if (readback_a !== 8'hF7 || err_a !== 1'b1) begin
      n_fail++;
      $display("FAIL fault_result: readback %h err %b expected f7 1", readback_a, err_a);
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (err_a !== 1'b1) begin
      n_fail++;
      $display("FAIL fault_sticky: got %b expected 1", err_a);
    end
    image_a = 8'h00; verify_a = 1'b0; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    n_cmp++;
    if (err_a !== 1'b0 || busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL fault_clear: err %b busy %b expected 0 1", err_a, busy_a);
    end
    repeat (40) @(negedge clk);
    n_cmp++;
    if (busy_a !== 1'b0 || err_a !== 1'b0) begin
      n_fail++;
      $display("FAIL fault_reload_end: busy %b err %b expected 0 0", busy_a, err_a);
    end
  endtask

  task automatic test_busy();
    int dc, bc;
    prep_a(8'h3C, 1'b0);
    // Start mid-shift and again in the DONE cycle: both must be ignored
    run_a(8'hA5, 1'b0, 10, 1'b1, dc, bc);
    repeat (10) @(negedge clk);
    n_cmp++;
    if (dones_a !== 1 || busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_single_done: dones %0d busy %b expected 1 0", dones_a, busy_a);
    end
    n_cmp++;
    if (chain_a !== 8'hA5 || readback_a !== 8'h3C) begin
      n_fail++;
      $display("FAIL busy_loaded: chain %h readback %h expected a5 3c", chain_a, readback_a);
    end
    n_cmp++;
    if (dc !== 37 || bc !== 36 || edges_a !== 8) begin
      n_fail++;
      $display("FAIL busy_timing: done %0d busy %0d edges %0d expected 37 36 8", dc, bc, edges_a);
    end
  endtask

  task automatic test_full();
    int dc, bc;
    logic [287:0] t;
    logic [263:0] img;
    for (int i = 0; i < 9; i++) t[i*32 +: 32] = $urandom;
    pre_b = ~t[263:0];
    for (int i = 0; i < 9; i++) t[i*32 +: 32] = $urandom;
    img = t[263:0];
    @(negedge clk);
    load_b = 1'b1;
    @(negedge clk);
    load_b = 1'b0;
    run_b(img, 1'b1, dc, bc);
    n_cmp++;
    if (readback_b !== img) begin
      n_fail++;
      $display("FAIL full_readback: got %h expected %h", readback_b, img);
    end
    n_cmp++;
    if (err_b !== 1'b0 || edges_b !== 528) begin
      n_fail++;
      $display("FAIL full_status: err %b edges %0d expected 0 528", err_b, edges_b);
    end
    n_cmp++;
    if (bc !== 4236 || dc !== 4237) begin
      n_fail++;
      $display("FAIL full_timing: busy %0d done %0d expected 4236 4237", bc, dc);
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rst_n = 1'b0;
    start_a = 1'b0; verify_a = 1'b0; image_a = '0;
    start_b = 1'b0; verify_b = 1'b0; image_b = '0;
    load_a = 1'b0; stuck_a = 1'b0; pre_a = '0;
    load_b = 1'b0; pre_b = '0;
    test_reset();
    test_reset_mid();
    test_single();
    test_verify_good();
    test_verify_fault();
    test_busy();
    test_full();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
